lighting_zone_ctrl: RTL and testbench
=====================================

LIGHTING_ZONE_CTRL -- requirements
Module: lighting_zone_ctrl

Interface
REQ-001 Parameter N_ZONES, default 4: number of independent lighting zones, 1..16.
REQ-002 Parameter HOLD_CYCLES, default 1000: auto-mode off-delay after presence loss, in clk cycles, >=1.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mode_btn  input  N_ZONES  per-zone auto/manual toggle request, level, rising-edge detected.
REQ-006 lamp_btn  input  N_ZONES  per-zone manual on/off toggle request, level, rising-edge detected.
REQ-007 presence  input  N_ZONES  per-zone occupancy sensor, level.
REQ-008 dark  input  1  global ambient sensor, 1 = insufficient daylight.
REQ-009 lamp  output  N_ZONES  per-zone lamp drive, 1 = on.
REQ-010 manual_led  output  N_ZONES  per-zone indicator, 1 = zone in manual mode.
REQ-011 hold_active  output  N_ZONES  per-zone indicator, 1 = off-delay timer running.

Function
REQ-012 Each zone SHALL run an independent Moore FSM with states AUTO_OFF, AUTO_ON, AUTO_HOLD, MAN_OFF, MAN_ON.
REQ-013 Button edge: rising edge on a bit = sampled 1 at the current clk edge and 0 at the previous one; a held button SHALL act once.
REQ-014 Per-cycle priority within a zone: master_off (if compiled) > mode_btn edge > lamp_btn edge > sensors.
REQ-015 mode_btn edge: any AUTO_* -> MAN_OFF; any MAN_* -> AUTO_OFF.
REQ-016 lamp_btn edge: MAN_OFF <-> MAN_ON; ignored in AUTO_* states.
REQ-017 AUTO_OFF -> AUTO_ON when presence && dark.
REQ-018 AUTO_ON -> AUTO_OFF when !dark; else -> AUTO_HOLD when !presence, loading timer with HOLD_CYCLES-1.
REQ-019 AUTO_HOLD: !dark -> AUTO_OFF; else presence -> AUTO_ON; else timer==0 -> AUTO_OFF; else timer decrements by 1.
REQ-020 Timer width $clog2(HOLD_CYCLES+1) bits per zone; no wrap (never decremented below 0); HOLD_CYCLES=1 yields exactly one AUTO_HOLD cycle.
REQ-021 AUTO_HOLD with presence loss lasts exactly HOLD_CYCLES cycles before AUTO_OFF.
REQ-022 Outputs SHALL decode only the state register: lamp=1 in AUTO_ON, AUTO_HOLD, MAN_ON; manual_led=1 in MAN_*; hold_active=1 in AUTO_HOLD.
REQ-023 Latency: an event sampled at clk edge k SHALL be visible on outputs after edge k, with no combinational input-to-output path.
REQ-024 Manual states SHALL ignore presence and dark entirely.
REQ-025 Unreachable state encodings SHALL recover to AUTO_OFF on the next clk edge.

Reset
REQ-026 On rst: all zones AUTO_OFF, timers 0, edge-detect registers 0; lamp, manual_led, hold_active all 0.
REQ-027 rst asserted mid-hold or in manual SHALL abort immediately; a button held high through reset release SHALL NOT produce an edge.

Configuration
REQ-028 Macro LIGHTING_MASTER_OFF_EN defined: adds input master_off (1 bit, level); while high, every zone goes to AUTO_OFF with timer cleared on each clk edge, overriding all buttons and sensors.
REQ-029 Macro undefined: no master_off port and no related logic; behaviour per REQ-012..025 only.

Structure
REQ-030 Shared package lighting_pkg SHALL hold the zone_state_t enum (5 states, 3-bit) and the output decode constants.
REQ-031 Per-zone logic SHALL be sub-module lighting_zone_fsm (state, timer, edge detect), instantiated N_ZONES times by generate; top level holds only fan-out and master_off wiring.

Verification (N_ZONES=4, HOLD_CYCLES=8 unless stated)
REQ-032 Reset, then dark=1, presence=4'b0001 -> lamp=4'b0001 after 1 edge; presence=0 -> hold_active[0]=1 for exactly 8 cycles, then lamp[0]=0.
REQ-033 Zone 0 in AUTO_HOLD, presence[0] re-asserted at hold cycle 5 -> AUTO_ON, hold_active[0]=0; later presence drop reloads full 8-cycle hold.
REQ-034 mode_btn[2] held high 10 cycles -> manual_led[2]=1, lamp[2]=0 once; two lamp_btn[2] pulses -> lamp[2] 1 then 0; presence/dark toggling meanwhile -> no change.
REQ-035 Same-cycle mode_btn[1] and lamp_btn[1] edges from AUTO_ON -> MAN_OFF (mode wins); dark drop during AUTO_HOLD -> AUTO_OFF immediately.
REQ-036 rst asserted during zone 3 hold at cycle 4 -> all outputs 0 asynchronously; with LIGHTING_MASTER_OFF_EN, master_off=1 with zones in MAN_ON and AUTO_ON -> all lamp=0, manual_led=0 after 1 edge.
REQ-037 HOLD_CYCLES=1, N_ZONES=1: presence drop -> hold_active=1 for exactly 1 cycle, then lamp=0.

Source files
------------

// File: rtl/lighting_pkg.sv
// Shared zone state encoding and output decode for the lighting zone controller.
// Optional build macro used by the design: LIGHTING_MASTER_OFF_EN.
package lighting_pkg;

  typedef enum logic [2:0] {
    AUTO_OFF  = 3'd0,
    AUTO_ON   = 3'd1,
    AUTO_HOLD = 3'd2,
    MAN_OFF   = 3'd3,
    MAN_ON    = 3'd4
  } zone_state_t;

  localparam int unsigned OUT_LAMP_BIT   = 0;
  localparam int unsigned OUT_MANUAL_BIT = 1;
  localparam int unsigned OUT_HOLD_BIT   = 2;

  // Decode words laid out as {hold_active, manual_led, lamp}.
  localparam logic [2:0] DEC_AUTO_OFF  = 3'b000;
  localparam logic [2:0] DEC_AUTO_ON   = 3'b001;
  localparam logic [2:0] DEC_AUTO_HOLD = 3'b101;
  localparam logic [2:0] DEC_MAN_OFF   = 3'b010;
  localparam logic [2:0] DEC_MAN_ON    = 3'b011;
  localparam logic [2:0] DEC_INVALID   = 3'b000;

  function automatic logic [2:0] zone_decode(input zone_state_t state);
    logic [2:0] dec;
    case (state)
      AUTO_OFF:  dec = DEC_AUTO_OFF;
      AUTO_ON:   dec = DEC_AUTO_ON;
      AUTO_HOLD: dec = DEC_AUTO_HOLD;
      MAN_OFF:   dec = DEC_MAN_OFF;
      MAN_ON:    dec = DEC_MAN_ON;
      default:   dec = DEC_INVALID;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/lighting_zone_fsm.sv
// One lighting zone: button edge detect, auto/manual Moore FSM and off-delay timer.
// Build macro LIGHTING_MASTER_OFF_EN adds the master_off override input.
module lighting_zone_fsm
  import lighting_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
`ifdef LIGHTING_MASTER_OFF_EN
  input  logic master_off,
`endif
  input  logic mode_btn,
  input  logic lamp_btn,
  input  logic presence,
  input  logic dark,
  output logic lamp,
  output logic manual_led,
  output logic hold_active
);

  localparam int unsigned TW = $clog2(HOLD_CYCLES + 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 1);

  zone_state_t   state_r;
  logic [TW-1:0] timer_r;
  logic          mode_prev_r;
  logic          lamp_prev_r;
  logic          armed_r;
  logic          mode_edge_s;
  logic          lamp_edge_s;
  logic [2:0]    dec_s;

  // armed_r stays low for the first edge after reset so a button held through release never fires.
  assign mode_edge_s = armed_r & mode_btn & ~mode_prev_r;
  assign lamp_edge_s = armed_r & lamp_btn & ~lamp_prev_r;

  // Zone state, off-delay timer and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= AUTO_OFF;
      timer_r     <= '0;
      mode_prev_r <= 1'b0;
      lamp_prev_r <= 1'b0;
      armed_r     <= 1'b0;
    end else begin
      mode_prev_r <= mode_btn;
      lamp_prev_r <= lamp_btn;
      armed_r     <= 1'b1;
`ifdef LIGHTING_MASTER_OFF_EN
      if (master_off) begin
        state_r <= AUTO_OFF;
        timer_r <= '0;
      end else begin
`else
      begin
`endif
        case (state_r)
          AUTO_OFF: begin
            if (mode_edge_s) begin
              state_r <= MAN_OFF;
            end else if (presence && dark) begin
              state_r <= AUTO_ON;
            end
          end
          AUTO_ON: begin
            if (mode_edge_s) begin
              state_r <= MAN_OFF;
            end else if (!dark) begin
              state_r <= AUTO_OFF;
            end else if (!presence) begin
              state_r <= AUTO_HOLD;
              timer_r <= HOLD_LOAD;
            end
          end
          AUTO_HOLD: begin
            if (mode_edge_s) begin
              state_r <= MAN_OFF;
              timer_r <= '0;
            end else if (!dark) begin
              state_r <= AUTO_OFF;
              timer_r <= '0;
            end else if (presence) begin
              state_r <= AUTO_ON;
              timer_r <= '0;
            end else if (timer_r == '0) begin
              state_r <= AUTO_OFF;
            end else begin
              timer_r <= timer_r - TW'(1);
            end
          end
          MAN_OFF: begin
            if (mode_edge_s) begin
              state_r <= AUTO_OFF;
            end else if (lamp_edge_s) begin
              state_r <= MAN_ON;
            end
          end
          MAN_ON: begin
            if (mode_edge_s) begin
              state_r <= AUTO_OFF;
            end else if (lamp_edge_s) begin
              state_r <= MAN_OFF;
            end
          end
          default: begin
            state_r <= AUTO_OFF;
            timer_r <= '0;
          end
        endcase
      end
    end
  end

  // Outputs come only from the state register, so inputs never reach them combinationally.
  assign dec_s       = zone_decode(state_r);
  assign lamp        = dec_s[OUT_LAMP_BIT];
  assign manual_led  = dec_s[OUT_MANUAL_BIT];
  assign hold_active = dec_s[OUT_HOLD_BIT];

endmodule

// File: rtl/lighting_zone_ctrl.sv
// Multi-zone lighting controller: fans per-zone I/O out to independent zone FSMs.
// Build macro LIGHTING_MASTER_OFF_EN adds a global master_off input shared by all zones.
module lighting_zone_ctrl
  import lighting_pkg::*;
#(
  parameter int unsigned N_ZONES     = 4,
  parameter int unsigned HOLD_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
`ifdef LIGHTING_MASTER_OFF_EN
  input  logic               master_off,
`endif
  input  logic [N_ZONES-1:0] mode_btn,
  input  logic [N_ZONES-1:0] lamp_btn,
  input  logic [N_ZONES-1:0] presence,
  input  logic               dark,
  output logic [N_ZONES-1:0] lamp,
  output logic [N_ZONES-1:0] manual_led,
  output logic [N_ZONES-1:0] hold_active
);

  for (genvar z = 0; z < N_ZONES; z++) begin : g_zone
    lighting_zone_fsm #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_zone (
      .clk         (clk),
      .rst         (rst),
`ifdef LIGHTING_MASTER_OFF_EN
      .master_off  (master_off),
`endif
      .mode_btn    (mode_btn[z]),
      .lamp_btn    (lamp_btn[z]),
      .presence    (presence[z]),
      .dark        (dark),
      .lamp        (lamp[z]),
      .manual_led  (manual_led[z]),
      .hold_active (hold_active[z])
    );
  end

endmodule

// File: tb/tb_lighting_zone_ctrl.sv
// Directed bench for lighting_zone_ctrl: a 4-zone/8-cycle instance and a 1-zone/1-cycle instance.
// The master_off section is built only when LIGHTING_MASTER_OFF_EN is defined.
module tb_lighting_zone_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mode_btn, lamp_btn, presence;
  logic       dark;
  logic [3:0] lamp, manual_led, hold_active;
  logic [0:0] mode_btn_b, lamp_btn_b, presence_b;
  logic       dark_b;
  logic [0:0] lamp_b, manual_led_b, hold_active_b;
`ifdef LIGHTING_MASTER_OFF_EN
  logic       master_off;
  logic       master_off_b;
`endif

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  lighting_zone_ctrl #(.N_ZONES(4), .HOLD_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef LIGHTING_MASTER_OFF_EN
    .master_off  (master_off),
`endif
    .mode_btn    (mode_btn),
    .lamp_btn    (lamp_btn),
    .presence    (presence),
    .dark        (dark),
    .lamp        (lamp),
    .manual_led  (manual_led),
    .hold_active (hold_active)
  );

  lighting_zone_ctrl #(.N_ZONES(1), .HOLD_CYCLES(1)) dut_b (
    .clk         (clk),
    .rst         (rst),
`ifdef LIGHTING_MASTER_OFF_EN
    .master_off  (master_off_b),
`endif
    .mode_btn    (mode_btn_b),
    .lamp_btn    (lamp_btn_b),
    .presence    (presence_b),
    .dark        (dark_b),
    .lamp        (lamp_b),
    .manual_led  (manual_led_b),
    .hold_active (hold_active_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive cycles with hold_active[z] high, bounded.
  task automatic count_hold(input int z, output int cnt);
    cnt = 0;
    while (hold_active[z] && cnt < 20) begin
      cnt++;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode_btn = 4'h0; lamp_btn = 4'h0; presence = 4'h0; dark = 1'b0;
    mode_btn_b = 1'b0; lamp_btn_b = 1'b0; presence_b = 1'b0; dark_b = 1'b0;
`ifdef LIGHTING_MASTER_OFF_EN
    master_off = 1'b0; master_off_b = 1'b0;
`endif
    tick(); tick();
    chk("rst_lamp",   16'(lamp),        16'h0);
    chk("rst_manual", 16'(manual_led),  16'h0);
    chk("rst_hold",   16'(hold_active), 16'h0);
    chk("rst_lamp_b", 16'(lamp_b),      16'h0);
    rst = 1'b0;
    tick();

    // Basic auto on and full-length hold on zone 0.
    dark = 1'b1; presence = 4'b0001;
    tick();
    chk("auto_on_lamp", 16'(lamp), 16'h1);
    presence = 4'b0000;
    tick();
    count_hold(0, n);
    chk("hold_len_8", 16'(n), 16'd8);
    chk("hold_end_lamp0", 16'(lamp), 16'h0);

    // Presence returns mid-hold, then a fresh drop reloads the full hold.
    presence = 4'b0001;
    tick();
    presence = 4'b0000;
    tick();
    repeat (4) tick();
    chk("hold_cycle5", 16'(hold_active), 16'h1);
    presence = 4'b0001;
    tick();
    chk("rehit_hold0", 16'(hold_active), 16'h0);
    chk("rehit_lamp0", 16'(lamp), 16'h1);
    presence = 4'b0000;
    tick();
    count_hold(0, n);
    chk("reload_hold_len_8", 16'(n), 16'd8);

    // Zone 2: held mode button toggles once; lamp button toggles; sensors ignored.
    mode_btn = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_mode_manual2", 16'(manual_led), 16'h4);
      chk("held_mode_lamp",    16'(lamp),       16'h0);
    end
    mode_btn = 4'b0000;
    tick();
    lamp_btn = 4'b0100;
    tick();
    chk("man_on_lamp2", 16'(lamp), 16'h4);
    lamp_btn = 4'b0000; presence = 4'b0100; dark = 1'b0;
    repeat (3) tick();
    chk("man_ignore_sens_lamp",   16'(lamp),       16'h4);
    chk("man_ignore_sens_manual", 16'(manual_led), 16'h4);
    dark = 1'b1; presence = 4'b0000;
    tick();
    lamp_btn = 4'b0100;
    tick();
    chk("man_off_lamp2", 16'(lamp), 16'h0);
    lamp_btn = 4'b0000; presence = 4'b0100;
    repeat (2) tick();
    chk("man_off_ignore_presence", 16'(lamp), 16'h0);
    presence = 4'b0000;
    tick();

    // Zone 1: simultaneous mode and lamp edges; dark loss during hold.
    presence = 4'b0010;
    tick();
    chk("z1_auto_on", 16'(lamp), 16'h2);
    mode_btn = 4'b0010; lamp_btn = 4'b0010;
    tick();
    chk("mode_wins_manual", 16'(manual_led), 16'h6);
    chk("mode_wins_lamp",   16'(lamp),       16'h0);
    mode_btn = 4'b0000; lamp_btn = 4'b0000;
    tick();
    mode_btn = 4'b0010;
    tick();
    chk("back_auto_manual", 16'(manual_led), 16'h4);
    chk("back_auto_off_lamp", 16'(lamp), 16'h0);
    mode_btn = 4'b0000;
    tick();
    chk("z1_auto_on_again", 16'(lamp), 16'h2);
    presence = 4'b0000;
    repeat (3) tick();
    chk("z1_in_hold", 16'(hold_active), 16'h2);
    dark = 1'b0;
    tick();
    chk("dark_drop_hold", 16'(hold_active), 16'h0);
    chk("dark_drop_lamp", 16'(lamp), 16'h0);
    dark = 1'b1;
    tick();

    // Zone 3 hold interrupted by asynchronous reset; button held through release.
    presence = 4'b1000;
    tick();
    presence = 4'b0000;
    tick();
    repeat (3) tick();
    chk("z3_hold_c4", 16'(hold_active), 16'h8);
    mode_btn = 4'b0100;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_lamp",   16'(lamp),        16'h0);
    chk("async_rst_manual", 16'(manual_led),  16'h0);
    chk("async_rst_hold",   16'(hold_active), 16'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("held_through_rst", 16'(manual_led), 16'h0);
    mode_btn = 4'b0000;
    tick();

`ifdef LIGHTING_MASTER_OFF_EN
    mode_btn = 4'b0001;
    tick();
    mode_btn = 4'b0000;
    tick();
    lamp_btn = 4'b0001;
    tick();
    lamp_btn = 4'b0000; presence = 4'b0010;
    tick();
    chk("pre_master_lamp", 16'(lamp), 16'h3);
    master_off = 1'b1;
    tick();
    chk("master_off_lamp",   16'(lamp),       16'h0);
    chk("master_off_manual", 16'(manual_led), 16'h0);
    master_off = 1'b0; presence = 4'b0000;
    tick();
`endif

    // One-zone, one-cycle hold instance.
    dark_b = 1'b1; presence_b = 1'b1;
    tick();
    chk("b_on_lamp", 16'(lamp_b), 16'h1);
    presence_b = 1'b0;
    tick();
    chk("b_hold1",      16'(hold_active_b), 16'h1);
    chk("b_hold1_lamp", 16'(lamp_b),        16'h1);
    tick();
    chk("b_after_hold", 16'(hold_active_b), 16'h0);
    chk("b_off_lamp",   16'(lamp_b),        16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
